// File: rtl/sea_byte_loader.sv
// Byte-serial front end for the SEA-96 core: parses header/key/data frames
// and presents one assembled li/ri/ki block at a time over a valid/ready handshake.
module sea_byte_loader #(
    parameter int HALF_W = 48
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [HALF_W-1:0] li,
    output logic [HALF_W-1:0] ri,
    output logic [HALF_W-1:0] ki,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              key_loaded,
    output logic              err
);
    localparam int HB = HALF_W / 8;
    localparam int CW = $clog2(2 * HB + 1);
    localparam int DW = 2 * HALF_W - 8;

    localparam logic [1:0] S_HDR     = 2'd0;
    localparam logic [1:0] S_KEY     = 2'd1;
    localparam logic [1:0] S_DATA    = 2'd2;
    localparam logic [1:0] S_PRESENT = 2'd3;

    logic [1:0]          r_state;
    logic [CW-1:0]       r_cnt;
    logic [HALF_W-1:0]   r_key_asm;
    logic [DW-1:0]       r_data_asm;
    logic                r_new_key;
    logic [HALF_W-1:0]   r_li;
    logic [HALF_W-1:0]   r_ri;
    logic [HALF_W-1:0]   r_ki;
    logic                r_out_valid;
    logic                r_in_ready;
    logic                r_key_loaded;
    logic                r_err;

    logic                  w_accept;
    logic                  w_take;
    logic [HALF_W-1:0]     w_key_next;
    logic [2*HALF_W-1:0]   w_data_full;

    // Handshake qualifiers and byte-shift views of the assembly registers.
    always_comb begin
        w_accept    = in_valid && r_in_ready;
        w_take      = r_out_valid && out_ready;
        w_key_next  = {r_key_asm[HALF_W-9:0], in_data};
        w_data_full = {r_data_asm, in_data};
    end

    // Frame parser: header decode, key/data assembly and block presentation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_HDR;
            r_cnt        <= {CW{1'b0}};
            r_key_asm    <= {HALF_W{1'b0}};
            r_data_asm   <= {DW{1'b0}};
            r_new_key    <= 1'b0;
            r_li         <= {HALF_W{1'b0}};
            r_ri         <= {HALF_W{1'b0}};
            r_ki         <= {HALF_W{1'b0}};
            r_out_valid  <= 1'b0;
            r_in_ready   <= 1'b1;
            r_key_loaded <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                S_HDR: begin
                    if (w_accept) begin
                        r_cnt <= {CW{1'b0}};
                        if (in_data[7:1] != 7'd0) begin
                            r_err <= 1'b1;
                        end else if (in_data[0]) begin
                            r_state   <= S_KEY;
                            r_new_key <= 1'b1;
                        end else if (r_key_loaded) begin
                            r_state   <= S_DATA;
                            r_new_key <= 1'b0;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_KEY: begin
                    if (w_accept) begin
                        r_key_asm <= w_key_next;
                        if (r_cnt == CW'(HB - 1)) begin
                            r_state <= S_DATA;
                            r_cnt   <= {CW{1'b0}};
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_data_asm <= w_data_full[DW-1:0];
                        if (r_cnt == CW'(2 * HB - 1)) begin
                            // Key is committed only with a complete frame.
                            r_li        <= w_data_full[2*HALF_W-1:HALF_W];
                            r_ri        <= w_data_full[HALF_W-1:0];
                            if (r_new_key) begin
                                r_ki         <= r_key_asm;
                                r_key_loaded <= 1'b1;
                            end else begin
                                r_ki <= r_ki;
                            end
                            r_state     <= S_PRESENT;
                            r_cnt       <= {CW{1'b0}};
                            r_out_valid <= 1'b1;
                            r_in_ready  <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                S_PRESENT: begin
                    if (w_take) begin
                        r_state     <= S_HDR;
                        r_cnt       <= {CW{1'b0}};
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_HDR;
                    r_cnt       <= {CW{1'b0}};
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign li         = r_li;
    assign ri         = r_ri;
    assign ki         = r_ki;
    assign key_loaded = r_key_loaded;
    assign err        = r_err;
endmodule

// File: doc/sea_byte_loader.md
Name: sea_byte_loader

Overview:
- Upstream input stage of the SEA-96 datapath.
- Accepts a byte-serial stream over a valid/ready handshake and assembles the 48-bit left half, 48-bit right half and 48-bit key word consumed by the cipher core as li/ri/ki.
- Presents one complete block at a time under a second valid/ready handshake.
- Frames carry an optional new key; otherwise the last loaded key is reused.

Parameters:
- HALF_W, 48, width of each half and of the key word in bits; must be a multiple of 8.
- HB = HALF_W/8 (localparam), bytes per half or key: 6 at default.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data valid this cycle.
- in_ready  output  1  loader accepts a byte this cycle.
- li  output  HALF_W  assembled left half (plaintext L).
- ri  output  HALF_W  assembled right half (plaintext R).
- ki  output  HALF_W  current key word.
- out_valid  output  1  li/ri/ki hold a complete block.
- out_ready  input  1  consumer takes the block.
- key_loaded  output  1  a key has been loaded since reset.
- err  output  1  sticky header-error flag.

Behaviour:
- Byte accepted: in_valid && in_ready at a rising edge. Block taken: out_valid && out_ready.
- Frame layout:
  - Header byte H.
  - If H[0]=1, HB key bytes follow.
  - Then 2*HB data bytes: li bytes first, then ri bytes, each MSB byte first (first data byte lands in li[HALF_W-1:HALF_W-8]).
- FSM states: HDR, KEY, DATA, PRESENT.
- Reset: state HDR; li=ri=ki=0; out_valid=0; key_loaded=0; err=0; byte counter=0. Reset mid-frame or in PRESENT discards partial or presented data.
- in_ready = 1 in HDR, KEY and DATA; 0 in PRESENT. out_valid = 1 only in PRESENT.
- HDR, header accepted:
  - H[7:1]!=0: set err, stay HDR; byte is consumed.
  - H[0]=1: go to KEY, counter=0.
  - H[0]=0 and key_loaded=1: go to DATA, counter=0.
  - H[0]=0 and key_loaded=0: set err, stay HDR.
- KEY:
  - Each accepted byte shifts into the key assembly register, MSB first.
  - On the HB-th byte: go to DATA, counter=0.
  - The ki output is not updated until the frame completes.
- DATA:
  - Each accepted byte shifts into the 2*HALF_W data assembly register.
  - On the 2*HB-th byte, at the same edge: li/ri copy from assembly (last byte in ri[7:0]); if the frame carried a key, ki and key_loaded=1 update; state becomes PRESENT.
  - out_valid is high the cycle after the final byte edge.
- PRESENT:
  - li/ri/ki stable.
  - On a block taken: next state HDR, out_valid=0 next cycle.
  - in_valid is ignored.
- Outputs li/ri/ki change only at frame completion or reset. They hold the last block after hand-off.
- Counter:
  - Width clog2(2*HB+1).
  - Increments only on accepted bytes.
  - Clears on every state entry.
- in_valid low mid-frame: stall, no state change, no timeout.
- err clears only on rst. err does not block operation.
- Min frame cycles: 1+2*HB (key reuse) or 1+3*HB (new key), plus ≥1 PRESENT cycle.

Test Plan:
- Reset, then header 0x01, key bytes 0x11..0x16, data bytes 0x21..0x2C, out_ready=1 → out_valid for 1 cycle, starting the cycle after the 19th byte; ki=0x111213141516, li=0x212223242526, ri=0x2728292A2B2C, key_loaded=1.
- Same block, then header 0x00 and data 0x31..0x3C → ki unchanged at 0x111213141516; li=0x313233343536, ri=0x3738393A3B3C; frame is 13 accepted bytes.
- After reset, header 0x00 → err=1, state stays HDR. Then header 0x80 → err stays 1, no out_valid. Then a valid 0x01 frame completes normally.
- Hold out_ready=0 for 10 cycles after completion → out_valid and li/ri/ki stable, in_ready=0, bytes offered are not consumed. out_ready=1 → out_valid=0 and in_ready=1 the next cycle.
- Toggle in_valid randomly (50%) through a new-key frame → outputs identical to the gap-free case.
- Assert rst after the 10th data byte → all outputs 0, key_loaded=0. A following 0x00 header sets err.
